// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// boot_loader_pkg
// Shared state encoding and command/acknowledge byte values for the loader.
// Revision: 1.0
// ============================================================================
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_BYTE = 3'd2,
        WRITE     = 3'd3,
        RUN       = 3'd4,
        STEP      = 3'd5,
        SEND_ACK  = 3'd6,
        WAIT_TX   = 3'd7
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [7:0] ACK_LOAD = 8'h4B;
    localparam logic [7:0] ACK_HALT = 8'h48;
    localparam logic [7:0] ACK_STEP = 8'h54;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// word_assembler
// Packs four bytes, first byte into the MSBs, into one 32-bit word.
// Revision: 1.0
// ============================================================================
module word_assembler (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;

    // Shifting left keeps earlier bytes in the upper lanes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx  <= 2'd0;
            r_word <= 32'h0000_0000;
        end else if (i_clear) begin
            r_idx  <= 2'd0;
            r_word <= 32'h0000_0000;
        end else if (i_byte_valid) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= {r_word[23:0], i_byte};
        end
    end

    assign o_word_valid = i_byte_valid && (r_idx == 2'd3);
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// boot_loader_ctrl
// UART command decoder: loads instruction memory, runs/steps the core, acks.
// Revision: 1.0
// ============================================================================
module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 8,
    parameter int CNT_W       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_done,
    input  logic                   i_tx_done,
    input  logic                   i_halt,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_data,
    output logic                   o_run,
    output logic                   o_step,
    output logic                   o_busy
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IMEM_ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_ack;
    logic [7:0]             w_ack_next;
    logic                   w_byte_valid;
    logic                   w_clear;
    logic                   w_word_valid;
    logic [31:0]            w_word;

    assign w_byte_valid = i_rx_done && (r_state == LOAD_BYTE);
    assign w_clear      = i_rx_done && (r_state == LOAD_CNT);

    word_assembler u_word_assembler (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_byte_valid (w_byte_valid),
        .i_byte       (i_rx_data),
        .i_clear      (w_clear),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        case (r_state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: w_state_next = LOAD_CNT;
                        CMD_RUN:  w_state_next = RUN;
                        CMD_STEP: w_state_next = STEP;
                        default:  w_state_next = IDLE;
                    endcase
                end
            end
            LOAD_CNT: begin
                if (i_rx_done) begin
                    if (i_rx_data == 8'h00) begin
                        w_state_next = SEND_ACK;
                        w_ack_next   = ACK_LOAD;
                    end else begin
                        w_state_next = LOAD_BYTE;
                    end
                end
            end
            LOAD_BYTE: begin
                if (w_word_valid) w_state_next = WRITE;
            end
            WRITE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = SEND_ACK;
                    w_ack_next   = ACK_LOAD;
                end else begin
                    w_state_next = LOAD_BYTE;
                end
            end
            RUN: begin
                if (i_halt) begin
                    w_state_next = SEND_ACK;
                    w_ack_next   = ACK_HALT;
                end
            end
            STEP: begin
                w_state_next = SEND_ACK;
                w_ack_next   = ACK_STEP;
            end
            SEND_ACK: w_state_next = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_ack   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            if (w_clear && (i_rx_data != 8'h00)) begin
                r_cnt  <= CNT_W'(i_rx_data);
                r_addr <= '0;
            end else if (r_state == WRITE) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_addr <= r_addr + IMEM_ADDR_W'(1);
            end
        end
    end

    // Halt gates o_run combinationally so the core never runs in the halt cycle.
    assign o_run       = (r_state == RUN) && !i_halt;
    assign o_step      = (r_state == STEP);
    assign o_imem_we   = (r_state == WRITE);
    assign o_imem_addr = r_addr;
    assign o_imem_data = w_word;
    assign o_tx_start  = (r_state == SEND_ACK);
    assign o_tx_data   = ((r_state == SEND_ACK) || (r_state == WAIT_TX)) ? r_ack : 8'h00;
    assign o_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// tb_boot_loader_ctrl
// Directed stimulus with an event-queue model of writes, acks, steps and run.
// Revision: 1.0
// ============================================================================
module tb_boot_loader_ctrl;

    localparam int AW = 2;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic          rx_done   = 1'b0;
    logic          tx_done   = 1'b0;
    logic          halt      = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          run;
    logic          step;
    logic          busy;

    boot_loader_ctrl #(.IMEM_ADDR_W(AW), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_tx_done   (tx_done),
        .i_halt      (halt),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_data (imem_data),
        .o_run       (run),
        .o_step      (step),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct { int c; logic [7:0] b; } ack_t;

    wr_t        wq[$];
    ack_t       aq[$];
    int         sq[$];
    int         run_lo = 1, run_hi = 0, run_seen = 0, last_ack = 0;
    logic       hold_tx = 1'b0;
    logic [7:0] cur_ack = 8'h00;
    logic [7:0] payload [0:19];
    int         total = 0, bad = 0, npulse;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]};
    endfunction

    function automatic logic [AW-1:0] model_addr(input int i);
        return AW'(i % (1 << AW));
    endfunction

    task automatic push_ack(input int c, input logic [7:0] b);
        aq.push_back('{c: c, b: b});
        last_ack = c;
    endtask

    task automatic send_byte(input logic [7:0] b, output int win);
        @(posedge clk); #1;
        rx_data = b; rx_done = 1'b1; win = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wait_win(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic finish_tx();
        @(posedge clk); #1; tx_done = 1'b1;
        @(posedge clk); #1; tx_done = 1'b0;
    endtask

    // Load command: count n, then nbytes of payload; expectations follow the 4th byte of each word.
    task automatic load_cmd(input int n, input int nbytes);
        int w;
        send_byte(8'h4C, w);
        send_byte(8'(n), w);
        if (n == 0) push_ack(w + 1, 8'h4B);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(payload[i], w);
            if (i % 4 == 3) begin
                wq.push_back('{c: w + 1, a: model_addr(i / 4), d: model_word(i / 4)});
                if (i / 4 == n - 1) push_ack(w + 2, 8'h4B);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_data"},   tx_data,   0);
        chk({tag, "_tx_start"},  tx_start,  0);
        chk({tag, "_imem_we"},   imem_we,   0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_data"}, imem_data, 0);
        chk({tag, "_run"},       run,       0);
        chk({tag, "_step"},      step,      0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    always @(negedge clk) begin
        npulse = int'(imem_we) + int'(step) + int'(tx_start);
        chk("pulse_exclusive", npulse > 1, 0);
        chk("run_level", run, (cyc >= run_lo) && (cyc <= run_hi));
        if (run) run_seen++;

        if (wq.size() == 0) chk("we_spurious", imem_we, 0);
        else if (imem_we || wq[0].c <= cyc) begin
            chk("we_cycle", cyc, wq[0].c);
            chk("we_level", imem_we, 1);
            chk("we_addr", imem_addr, wq[0].a);
            chk("we_data", imem_data, wq[0].d);
            void'(wq.pop_front());
        end

        if (sq.size() == 0) chk("step_spurious", step, 0);
        else if (step || sq[0] <= cyc) begin
            chk("step_cycle", cyc, sq[0]);
            chk("step_level", step, 1);
            void'(sq.pop_front());
        end

        if (hold_tx) begin
            chk("tx_hold", tx_data, cur_ack);
            chk("tx_busy", busy, 1);
            if (tx_done) hold_tx = 1'b0;
        end

        if (aq.size() == 0) chk("tx_spurious", tx_start, 0);
        else if (tx_start || aq[0].c <= cyc) begin
            chk("tx_cycle", cyc, aq[0].c);
            chk("tx_level", tx_start, 1);
            chk("tx_byte", tx_data, aq[0].b);
            cur_ack = aq[0].b;
            hold_tx = 1'b1;
            void'(aq.pop_front());
        end
    end

    initial begin
        int w;
        #2;
        chk_all_zero("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Two-word load.
        payload[0] = 8'h20; payload[1] = 8'h01; payload[2] = 8'h00; payload[3] = 8'h05;
        payload[4] = 8'hAC; payload[5] = 8'h01; payload[6] = 8'h00; payload[7] = 8'h04;
        chk("pin_word0", model_word(0), 32'h20010005);
        chk("pin_word1", model_word(1), 32'hAC010004);
        load_cmd(2, 8);
        wait_win(last_ack + 2);
        finish_tx();
        chk("load_busy_after", busy, 0);

        // Zero count.
        load_cmd(0, 0);
        wait_win(last_ack + 2);
        finish_tx();
        chk("zero_busy_after", busy, 0);

        // Unknown byte, then single step with bytes arriving during WAIT_TX.
        send_byte(8'h7A, w);
        chk("noise_idle", busy, 0);
        send_byte(8'h53, w);
        sq.push_back(w + 1);
        push_ack(w + 2, 8'h54);
        wait_win(w + 3);
        send_byte(8'h4C, w);
        send_byte(8'h53, w);
        finish_tx();
        chk("step_busy_after", busy, 0);
        repeat (6) @(posedge clk);
        #1 chk("step_still_idle", busy, 0);

        // Free run, halt after 20 cycles.
        run_seen = 0;
        send_byte(8'h52, w);
        run_lo = w + 1; run_hi = w + 20;
        wait_win(w + 21);
        halt = 1'b1;
        push_ack(w + 22, 8'h48);
        wait_win(w + 23);
        finish_tx();
        halt = 1'b0;
        chk("run_cycles", run_seen, 20);

        // Halt already high on entry.
        halt = 1'b1;
        run_seen = 0;
        send_byte(8'h52, w);
        push_ack(w + 2, 8'h48);
        chk("run_entry_busy", busy, 1);
        wait_win(w + 3);
        finish_tx();
        halt = 1'b0;
        chk("run_entry_cycles", run_seen, 0);

        // Five words into a four-entry address space.
        for (int i = 0; i < 20; i++) payload[i] = 8'(8'h10 + i);
        chk("pin_addr4", model_addr(4), 0);
        chk("pin_word4", model_word(4), 32'h20212223);
        load_cmd(5, 20);
        wait_win(last_ack + 2);
        finish_tx();
        chk("wrap_busy_after", busy, 0);

        // Reset after two bytes of the second word.
        load_cmd(2, 6);
        reset_n = 1'b0;
        #1 chk_all_zero("rst_load");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
        chk("pin_word_fresh", model_word(0), 32'hDEADBEEF);
        load_cmd(1, 4);
        wait_win(last_ack + 2);
        finish_tx();
        chk("fresh_busy_after", busy, 0);

        // Reset while running.
        send_byte(8'h52, w);
        run_lo = w + 1; run_hi = w + 1000;
        wait_win(w + 4);
        run_hi = cyc - 1;
        reset_n = 1'b0;
        #1 chk_all_zero("rst_run");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        chk("writes_left", wq.size(), 0);
        chk("acks_left", aq.size(), 0);
        chk("steps_left", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- UART-driven loader/debug controller for the MIPS core.
- Decodes command bytes from the UART receiver.
- Assembles 32-bit big-endian instruction words and writes them sequentially into instruction memory.
- Starts free-run or single-step execution and returns one acknowledge byte to the UART transmitter per command.

Parameters:
- IMEM_ADDR_W, 8, instruction-memory word-address width.
- CNT_W, 8, width of the load-count field (max instructions per load command).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  received UART byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe, new byte on i_rx_data.
- i_tx_done  in  1  one-cycle strobe, transmitter finished current byte.
- i_halt  in  1  core reached halt; level, sampled in RUN.
- o_tx_data  out  8  byte to transmit; held stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle transmit request.
- o_imem_we  out  1  one-cycle instruction-memory write enable.
- o_imem_addr  out  IMEM_ADDR_W  write word address.
- o_imem_data  out  32  assembled instruction word.
- o_run  out  1  core clock-enable for free run; level.
- o_step  out  1  one-cycle single-step enable.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Write address=0, byte index=0, count=0.
- Bytes are consumed only on cycles with i_rx_done=1. i_rx_done in RUN, STEP, SEND_ACK or WAIT_TX is ignored (byte dropped).
- IDLE, on i_rx_done:
  - 'L' (8'h4C) -> LOAD_CNT.
  - 'R' (8'h52) -> RUN.
  - 'S' (8'h53) -> STEP.
  - Any other value is ignored; stay IDLE, no ack.
- LOAD_CNT: the next byte is N.
  - N=0 -> SEND_ACK with 'K' (8'h4B).
  - Otherwise latch N, address=0, byte index=0 -> LOAD_BYTE.
- LOAD_BYTE: byte k (0..3) goes to word bits [31-8k -: 8], MSB first.
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_addr=current address, o_imem_data=assembled word.
  - The write is visible the cycle after the 4th i_rx_done.
  - Then address+1 (wraps modulo 2^IMEM_ADDR_W, no error), N-1.
  - If N-1=0 -> SEND_ACK 'K'; else -> LOAD_BYTE with index=0.
- RUN:
  - o_run=1 from the cycle after 'R' is accepted.
  - On the first cycle with i_halt=1, o_run=0 that same cycle (combinational from state and i_halt) -> SEND_ACK 'H' (8'h48).
  - i_halt already high on RUN entry gives one cycle in RUN with o_run=0, then ack.
- STEP: o_step=1 for exactly one cycle -> SEND_ACK 'T' (8'h54).
- SEND_ACK: o_tx_start=1 for one cycle, o_tx_data=ack byte -> WAIT_TX.
- WAIT_TX: hold o_tx_data; on i_tx_done -> IDLE.
- Reset mid-operation (LOAD, RUN, WAIT_TX): everything aborts immediately.
  - o_run, o_imem_we and o_tx_start drop asynchronously.
  - Any partial word is discarded; no ack is sent.
- o_imem_we, o_step and o_tx_start are never high in the same cycle.

Decomposition:
- Package boot_loader_pkg holds:
  - state enum (IDLE, LOAD_CNT, LOAD_BYTE, WRITE, RUN, STEP, SEND_ACK, WAIT_TX);
  - command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP);
  - ack byte constants (ACK_LOAD, ACK_HALT, ACK_STEP).
- One natural sub-module: word_assembler.
  - Byte-index counter plus 32-bit shift/insert register.
  - Inputs: byte strobe and clear. Outputs: word_valid and 32-bit word.
- The FSM and address/count logic stay in the top level.

Test Plan:
- Load: 'L', 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04 -> expected:
  - o_imem_we pulses twice: addr 0 data 32'h20010005, then addr 1 data 32'hAC010004.
  - Each pulse lands the cycle after the 4th byte.
  - Then o_tx_start with o_tx_data=8'h4B.
- Load count zero: 'L', 8'h00 -> no o_imem_we; ack 8'h4B; o_busy=0 after i_tx_done.
- Run/halt: 'R', hold i_halt=0 for 20 cycles, then 1 -> expected:
  - o_run high exactly 20 cycles, low in the i_halt cycle;
  - ack 8'h48.
- Step and noise: byte 8'h7A in IDLE -> no response. Then 'S' -> expected:
  - single o_step pulse;
  - ack 8'h54;
  - bytes received during WAIT_TX are ignored.
- Wrap with IMEM_ADDR_W=2: 'L', N=5, 20 data bytes -> writes to addr 0,1,2,3,0; 5th word overwrites addr 0; ack 8'h4B.
- Reset mid-load: assert i_reset_n=0 after 2 bytes of the second word -> expected:
  - outputs 0 immediately;
  - after release, a fresh 'L', 8'h01 plus 4 bytes writes to addr 0.
